// File: rtl/learn_arbiter.sv
// Round-robin sequencer of per-port source-address learn requests into the address table,
// interleaved with periodic aging sweeps so the two never collide on the table interface.
module learn_arbiter #(
    parameter int NUM_PORTS  = 8,
    parameter int ADDR_WIDTH = 48,
    parameter int AGE_PERIOD = 1024,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            src_valid_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] src_addr_i,
    output logic [NUM_PORTS-1:0]            src_ready_o,
    output logic                            learn_valid_o,
    output logic [ADDR_WIDTH-1:0]           learn_addr_o,
    output logic [PW-1:0]                   learn_port_o,
    input  logic                            learn_ready_i,
    output logic                            age_req_o,
    input  logic                            age_ack_i
);

    localparam int CW = $clog2(AGE_PERIOD);
    localparam logic [CW-1:0] AGE_LAST = CW'(AGE_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        AGE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   slot_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0]    pending;
    logic [NUM_PORTS-1:0]    capture;
    logic [PW-1:0]           last_grant;
    logic [PW-1:0]           grant_port;
    logic [PW-1:0]           cand;
    logic                    grant_found;
    logic [CW-1:0]           age_cnt;
    logic                    age_due;

    // The ready register doubles as the inverted pending bit of each one-entry slot.
    assign pending = ~src_ready_o;
    assign capture = src_valid_i & src_ready_o;

    always_comb begin
        grant_found = 1'b0;
        grant_port  = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(last_grant) + i) % NUM_PORTS);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_port  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (capture[p]) begin
                slot_addr[p] <= src_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // The handshake release below overrides the capture mask for the granted bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            src_ready_o   <= '1;
            learn_valid_o <= 1'b0;
            learn_addr_o  <= '0;
            learn_port_o  <= '0;
            age_req_o     <= 1'b0;
            age_cnt       <= '0;
            age_due       <= 1'b0;
            last_grant    <= PW'(NUM_PORTS - 1);
        end else begin
            src_ready_o <= src_ready_o & ~capture;

            if (!age_due) begin
                if (age_cnt == AGE_LAST) begin
                    age_due <= 1'b1;
                    age_cnt <= '0;
                end else begin
                    age_cnt <= age_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (age_due) begin
                        age_req_o <= 1'b1;
                        state     <= AGE;
                    end else if (grant_found) begin
                        learn_valid_o <= 1'b1;
                        learn_addr_o  <= slot_addr[grant_port];
                        learn_port_o  <= grant_port;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (learn_ready_i) begin
                        src_ready_o[learn_port_o] <= 1'b1;
                        last_grant                <= learn_port_o;
                        learn_valid_o             <= 1'b0;
                        state                     <= IDLE;
                    end
                end
                AGE: begin
                    if (age_ack_i) begin
                        age_req_o <= 1'b0;
                        age_due   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
